// File: rtl/uart_tx_frame.sv
// UART transmit framing stage: start bit, LSB-first payload, optional parity, stop bit(s).
// Define UART_TX_STOP2_EN to stretch STOP to two cycles (accept only in the second one).
module uart_tx_frame #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_Valid,
    input  logic                  PAR_EN,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CntLast = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_q, par_d;
    logic                  stop_final;
    logic                  accept;

`ifdef UART_TX_STOP2_EN
    logic stop2_q, stop2_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stop2_q <= 1'b0;
        end else begin
            stop2_q <= stop2_d;
        end
    end

    assign stop_final = stop2_q;
`else
    assign stop_final = 1'b1;
`endif

    assign accept = DATA_Valid && ((state_q == StIdle) || ((state_q == StStop) && stop_final));

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        par_en_d = par_en_q;
        par_d    = par_q;
`ifdef UART_TX_STOP2_EN
        stop2_d  = stop2_q;
`endif
        case (state_q)
            StIdle: begin
            end
            StStart: begin
                // Parity stage output is only valid now; later pulses may reload it.
                par_d   = par_bit;
                state_d = StData;
            end
            StData: begin
                shift_d = shift_q >> 1;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? StParity : StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
                state_d = StStop;
            end
            StStop: begin
`ifdef UART_TX_STOP2_EN
                if (!stop2_q) begin
                    stop2_d = 1'b1;
                end else begin
                    stop2_d = 1'b0;
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            shift_d  = P_DATA;
            par_en_d = PAR_EN;
            cnt_d    = '0;
            state_d  = StStart;
`ifdef UART_TX_STOP2_EN
            stop2_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
        end
    end

    // Outputs decode only registered state, so reset forces them idle at once.
    always_comb begin
        TX_OUT = 1'b1;
        Busy   = 1'b0;
        case (state_q)
            StStart: begin
                TX_OUT = 1'b0;
                Busy   = 1'b1;
            end
            StData: begin
                TX_OUT = shift_q[0];
                Busy   = 1'b1;
            end
            StParity: begin
                TX_OUT = par_q;
                Busy   = 1'b1;
            end
            default: begin
                TX_OUT = 1'b1;
                Busy   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame (8-bit payload).
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = 8'h00;
    logic       DATA_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       par_bit = 1'b0;
    logic       TX_OUT;
    logic       Busy;

    int checks = 0;
    int failures = 0;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_Valid (DATA_Valid),
        .PAR_EN     (PAR_EN),
        .par_bit    (par_bit),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic etx, input logic ebusy);
        checks++;
        assert (TX_OUT === etx) else begin
            failures++;
            $error("FAIL %s TX_OUT: observed %b expected %b", tag, TX_OUT, etx);
        end
        checks++;
        assert (Busy === ebusy) else begin
            failures++;
            $error("FAIL %s Busy: observed %b expected %b", tag, Busy, ebusy);
        end
    endtask

    task automatic step_chk(input string tag, input logic etx, input logic ebusy);
        @(posedge CLK);
        #1;
        chk(tag, etx, ebusy);
    endtask

    // Accepts d on the next edge, then checks start, data and optional parity slots.
    // glitch: pulse DATA_Valid with zero data and force par_bit low mid-payload.
    task automatic send(input string tag, input logic [7:0] d, input logic pe, input logic pb,
                        input logic glitch);
        P_DATA     = d;
        PAR_EN     = pe;
        DATA_Valid = 1'b1;
        step_chk({tag, " start"}, 1'b0, 1'b1);
        DATA_Valid = 1'b0;
        par_bit    = pb;
        P_DATA     = ~d;
        PAR_EN     = ~pe;
        for (int i = 0; i < 8; i++) begin
            step_chk($sformatf("%s d%0d", tag, i), d[i], 1'b1);
            if (glitch && i == 2) begin
                DATA_Valid = 1'b1;
                P_DATA     = 8'h00;
                par_bit    = 1'b0;
            end else if (glitch && i == 3) begin
                DATA_Valid = 1'b0;
            end
        end
        if (pe) step_chk({tag, " parity"}, pb, 1'b1);
    endtask

    task automatic stop_chk(input string tag);
        step_chk({tag, " stop"}, 1'b1, 1'b0);
`ifdef UART_TX_STOP2_EN
        step_chk({tag, " stop2"}, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        // Reset held with a pending request: line stays idle.
        DATA_Valid = 1'b1;
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b1;
        #1;
        chk("rst async", 1'b1, 1'b0);
        step_chk("rst hold1", 1'b1, 1'b0);
        step_chk("rst hold2", 1'b1, 1'b0);
        RST = 1'b0;

        // A5 with parity: 0,1,0,1,0,0,1,0,1,1,1
        send("a5", 8'hA5, 1'b1, 1'b1, 1'b0);
        stop_chk("a5");
        step_chk("a5 idle", 1'b1, 1'b0);
        step_chk("a5 idle2", 1'b1, 1'b0);

        // 3C without parity: 0,0,0,1,1,1,1,0,0,1
        send("3c", 8'h3C, 1'b0, 1'b1, 1'b0);
        stop_chk("3c");
        step_chk("3c idle", 1'b1, 1'b0);

        // Back-to-back: 55 then FF requested while in PARITY/STOP.
        send("55", 8'h55, 1'b1, 1'b0, 1'b0);
        DATA_Valid = 1'b1;
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b1;
        stop_chk("55");
        send("ff", 8'hFF, 1'b1, 1'b0, 1'b0);
        stop_chk("ff");
        step_chk("ff idle", 1'b1, 1'b0);

        // Ignored request mid-frame; parity slot keeps captured value.
        send("a5g", 8'hA5, 1'b1, 1'b1, 1'b1);
        stop_chk("a5g");
        step_chk("a5g idle", 1'b1, 1'b0);

        // Reset at data bit 3.
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b1;
        DATA_Valid = 1'b1;
        step_chk("ab start", 1'b0, 1'b1);
        DATA_Valid = 1'b0;
        par_bit    = 1'b1;
        for (int i = 0; i < 4; i++) step_chk($sformatf("ab d%0d", i), P_DATA[i], 1'b1);
        #2 RST = 1'b1;
        #1;
        chk("ab rst async", 1'b1, 1'b0);
        step_chk("ab rst hold", 1'b1, 1'b0);
        RST = 1'b0;
        step_chk("ab idle", 1'b1, 1'b0);
        send("81", 8'h81, 1'b0, 1'b0, 1'b0);
        stop_chk("81");
        step_chk("81 idle", 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART transmit framing stage: accepts a parallel word, serialises it LSB-first with start, optional parity and stop bits onto the TX line, one bit per CLK cycle. It sits directly downstream of the TX parity generator. It shares DATA_Valid/P_DATA with that generator and consumes its registered par_bit output. CLK is the baud-rate clock; no oversampling is done here.

## Interface
- DATA_WIDTH, default 8: payload bits per frame (≥ 2).

- CLK  in  1  baud clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- P_DATA  in  DATA_WIDTH  parallel word; sampled only on accept.
- DATA_Valid  in  1  request to send P_DATA; single-cycle pulse or level.
- PAR_EN  in  1  1 = insert parity bit; sampled only on accept.
- par_bit  in  1  parity from parity stage; valid from the cycle after accept.
- TX_OUT  out  1  serial line; idle high.
- Busy  out  1  frame in progress (START/DATA/PARITY).

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept = DATA_Valid && (IDLE || final STOP cycle). On accept: latch P_DATA into shift register, latch PAR_EN, clear bit counter, go to START.
- START (1 cycle): TX_OUT=0. Capture par_bit into internal register at the end of START. This protects against later DATA_Valid pulses that re-load the parity stage.
- DATA (DATA_WIDTH cycles): TX_OUT = shift[0], shift right each cycle. Counter 0..DATA_WIDTH-1, width $clog2(DATA_WIDTH). Leave when counter == DATA_WIDTH-1.
- After DATA: go to PARITY if latched PAR_EN, else STOP.
- PARITY (1 cycle): TX_OUT = captured parity.
- STOP: TX_OUT=1. On accept go to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- IDLE: TX_OUT=1.
- DATA_Valid during START/DATA/PARITY (or non-final STOP cycle) is ignored. No queueing, no error flag. Upstream must hold DATA_Valid until Busy low to avoid loss.
- TX_OUT and Busy are registered (or decoded purely from registers). There is no combinational path from any input to any output.

## Timing
- Reset values: state=IDLE, TX_OUT=1, Busy=0, shift register=0, counter=0, captured parity=0.
- Accept at edge k: TX_OUT=0 and Busy=1 from edge k. Bit i of P_DATA drives the line from edge k+1+i.
- Frame length = 1 + DATA_WIDTH + PAR_EN + stop cycles. Default is 11 cycles (parity on) or 10 (parity off).
- Busy falls at the edge entering STOP and stays 0 through STOP and IDLE.
- RST asserted mid-frame: TX_OUT=1 and Busy=0 immediately (asynchronous). The partial frame is abandoned and not resumed. The first accept after release produces a complete frame.
- PAR_EN or P_DATA changes after accept have no effect on the current frame.

## Configuration
- UART_TX_STOP2_EN defined: STOP lasts 2 cycles, both TX_OUT=1. Accept is possible only in the second STOP cycle. Frame length +1.
- Not defined: single stop cycle, accept permitted in it.

## Test plan
- Reset: hold RST=1 with DATA_Valid=1 → TX_OUT=1, Busy=0. Release → frame begins on the next accept edge.
- P_DATA=8'hA5, PAR_EN=1, bench drives par_bit=1 one cycle after accept → TX_OUT sequence 0,1,0,1,0,0,1,0,1,1,1, then idle 1. Busy=1 for exactly 10 cycles.
- P_DATA=8'h3C, PAR_EN=0 → 0,0,0,1,1,1,1,0,0,1 (10 cycles), no parity slot.
- Back-to-back: 8'h55 accepted, DATA_Valid with 8'hFF asserted in STOP → next START immediately follows the stop bit, no idle cycle. Second frame is 0,1×8,par,1.
- Ignore/robustness: DATA_Valid pulse with P_DATA=8'h00 and par_bit forced 0 during DATA of an 8'hA5 frame → transmitted frame unchanged (parity slot still the captured 1).
- Reset mid-frame at data bit 3 → TX_OUT=1, Busy=0 asynchronously. Next accept of 8'h81 gives a clean 0,1,0,0,0,0,0,0,1,…. With UART_TX_STOP2_EN, repeat the 8'hA5 case → 12-cycle frame ending 1,1.
